// File: rtl/ss_seq_ctrl_pkg.sv
// rtl/ss_seq_ctrl_pkg.sv - shared types, defaults and address helpers for the save-state sequencer
// Purpose: sequencer state enumeration, strobe timer phases, parameter
// defaults and the per-slot snapshot memory layout.
package ss_seq_ctrl_pkg;

    localparam int SS_LEN_DEF    = 128;
    localparam int IDX_ADDR_DEF  = 127;
    localparam int RD_SETTLE_DEF = 4;
    localparam int WE_HOLD_DEF   = 8;

    // Each mapper slot owns one SS_LEN-sized window of snapshot memory.
    localparam logic [15:0] SLOT_STRIDE = 16'h0080;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S_SET,
        ST_S_WR,
        ST_L_RD,
        ST_L_WE,
        ST_L_CHK,
        ST_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        SG_IDLE,
        SG_HOLD,
        SG_GAP,
        SG_WAIT
    } sg_phase_t;

    function automatic logic [15:0] slot_mem_base(input logic [3:0] slot);
        return {12'd0, slot} * SLOT_STRIDE;
    endfunction

    // 16-bit add; wraps modulo 2^16 by construction.
    function automatic logic [15:0] snap_addr(input logic [15:0] base, input logic [7:0] idx);
        return base + {8'd0, idx};
    endfunction

endpackage

// File: rtl/ss_seq_ctrl_if.sv
// rtl/ss_seq_ctrl_if.sv - mapper save-state bus plus snapshot memory bus
// Ports (master = sequencer):
//   ss_act/ss_we/ss_addr/ss_wdat  out  save-state bus towards the mapper
//   ss_rdat                       in   mapper save-state read data
//   mem_addr/mem_wdat/mem_we/mem_re out snapshot memory request
//   mem_rdat/mem_ack              in   snapshot memory response
interface ss_seq_ctrl_if;
    logic        ss_act;
    logic        ss_we;
    logic [7:0]  ss_addr;
    logic [7:0]  ss_wdat;
    logic [7:0]  ss_rdat;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdat;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdat;
    logic        mem_ack;

    modport master (
        output ss_act, ss_we, ss_addr, ss_wdat, mem_addr, mem_wdat, mem_we, mem_re,
        input  ss_rdat, mem_rdat, mem_ack
    );

    modport slave (
        input  ss_act, ss_we, ss_addr, ss_wdat, mem_addr, mem_wdat, mem_we, mem_re,
        output ss_rdat, mem_rdat, mem_ack
    );
endinterface

// File: rtl/ss_seq_ctrl_strobe_gen.sv
// rtl/ss_seq_ctrl_strobe_gen.sv - setup/hold timer for ss_we strobes and read settle waits
// Ports:
//   clk, rst_n  in   clock, asynchronous active-low reset
//   req         in   one-cycle start pulse, only honoured when idle
//   use_we      in   1: WE_HOLD-cycle ss_we strobe, 0: RD_SETTLE wait
//   we          out  registered ss_we
//   fin         out  high for the single cycle in which the requester may advance
// The requester drives addr/data on the edge that raises req, so they are
// stable for one cycle before we rises; fin comes in the cycle after we
// falls, giving one stable cycle after the strobe.
module ss_strobe_gen
    import ss_seq_ctrl_pkg::*;
#(
    parameter int WE_HOLD   = WE_HOLD_DEF,
    parameter int RD_SETTLE = RD_SETTLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic use_we,
    output logic we,
    output logic fin
);
    localparam logic [7:0] HOLD_LD   = 8'(WE_HOLD - 1);
    localparam logic [7:0] SETTLE_LD = 8'(RD_SETTLE - 1);

    sg_phase_t  phase;
    logic [7:0] cnt;

    assign fin = (phase == SG_GAP) || ((phase == SG_WAIT) && (cnt == 8'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= SG_IDLE;
            cnt   <= 8'd0;
            we    <= 1'b0;
        end else begin
            case (phase)
                SG_IDLE: begin
                    if (req) begin
                        cnt   <= use_we ? HOLD_LD : SETTLE_LD;
                        we    <= use_we;
                        phase <= use_we ? SG_HOLD : SG_WAIT;
                    end
                end
                SG_HOLD: begin
                    if (cnt == 8'd0) begin
                        we    <= 1'b0;
                        phase <= SG_GAP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SG_GAP: phase <= SG_IDLE;
                SG_WAIT: begin
                    if (cnt == 8'd0) phase <= SG_IDLE;
                    else cnt <= cnt - 8'd1;
                end
                default: phase <= SG_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ss_seq_ctrl.sv
// rtl/ss_seq_ctrl.sv - save-state sequencer: SAVE mapper state to memory, LOAD it back
// Ports:
//   clk, rst_n              in   clock, asynchronous active-low reset
//   start_save, start_load  in   one-cycle requests (SAVE wins if both)
//   busy                    out  accepted start until DONE exits
//   done                    out  one-cycle completion pulse
//   err                     out  sticky index mismatch seen during LOAD
//   bus                     master side of the save-state and memory buses
module ss_seq_ctrl
    import ss_seq_ctrl_pkg::*;
#(
    parameter int          SS_LEN    = SS_LEN_DEF,
    parameter int          IDX_ADDR  = IDX_ADDR_DEF,
    parameter int          RD_SETTLE = RD_SETTLE_DEF,
    parameter int          WE_HOLD   = WE_HOLD_DEF,
    parameter logic [15:0] MEM_BASE  = slot_mem_base(4'd0)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_save,
    input  logic          start_load,
    output logic          busy,
    output logic          done,
    output logic          err,
    ss_seq_ctrl_if.master bus
);
    localparam logic [7:0] LAST_IDX = 8'(SS_LEN - 1);
    localparam logic [7:0] IDX_A    = 8'(IDX_ADDR);

    seq_state_t  state;
    logic [7:0]  idx;
    logic [7:0]  ldat;
    logic [7:0]  nxt;
    logic        strb_req;
    logic        strb_use_we;
    logic        strb_we;
    logic        strb_fin;
    logic        ss_act_q;
    logic [7:0]  ss_addr_q;
    logic [7:0]  ss_wdat_q;
    logic [15:0] mem_addr_q;
    logic [7:0]  mem_wdat_q;
    logic        mem_we_q;
    logic        mem_re_q;

    assign nxt          = idx + 8'd1;
    assign bus.ss_act   = ss_act_q;
    assign bus.ss_we    = strb_we;
    assign bus.ss_addr  = ss_addr_q;
    assign bus.ss_wdat  = ss_wdat_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wdat = mem_wdat_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_re   = mem_re_q;

    ss_strobe_gen #(
        .WE_HOLD   (WE_HOLD),
        .RD_SETTLE (RD_SETTLE)
    ) u_strobe (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (strb_req),
        .use_we (strb_use_we),
        .we     (strb_we),
        .fin    (strb_fin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= 8'd0;
            ldat        <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            strb_req    <= 1'b0;
            strb_use_we <= 1'b0;
            ss_act_q    <= 1'b0;
            ss_addr_q   <= 8'd0;
            ss_wdat_q   <= 8'd0;
            mem_addr_q  <= 16'd0;
            mem_wdat_q  <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            done     <= 1'b0;
            strb_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_save || start_load) begin
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        ss_act_q <= 1'b1;
                        idx      <= 8'd0;
                        if (start_save) begin
                            ss_addr_q   <= 8'd0;
                            strb_req    <= 1'b1;
                            strb_use_we <= 1'b0;
                            state       <= ST_S_SET;
                        end else begin
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= snap_addr(MEM_BASE, 8'd0);
                            state      <= ST_L_RD;
                        end
                    end
                end
                ST_S_SET: begin
                    if (strb_fin) begin
                        mem_wdat_q <= bus.ss_rdat;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= snap_addr(MEM_BASE, idx);
                        state      <= ST_S_WR;
                    end
                end
                ST_S_WR: begin
                    if (bus.mem_ack) begin
                        mem_we_q <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx         <= nxt;
                            ss_addr_q   <= nxt;
                            strb_req    <= 1'b1;
                            strb_use_we <= 1'b0;
                            state       <= ST_S_SET;
                        end
                    end
                end
                ST_L_RD: begin
                    if (bus.mem_ack) begin
                        mem_re_q  <= 1'b0;
                        ldat      <= bus.mem_rdat;
                        ss_addr_q <= idx;
                        strb_req  <= 1'b1;
                        // The index byte is read-only in the mapper: verify it instead of writing it.
                        if (idx == IDX_A) begin
                            strb_use_we <= 1'b0;
                            state       <= ST_L_CHK;
                        end else begin
                            ss_wdat_q   <= bus.mem_rdat;
                            strb_use_we <= 1'b1;
                            state       <= ST_L_WE;
                        end
                    end
                end
                ST_L_WE, ST_L_CHK: begin
                    if (strb_fin) begin
                        if ((state == ST_L_CHK) && (bus.ss_rdat != ldat)) err <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx        <= nxt;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= snap_addr(MEM_BASE, nxt);
                            state      <= ST_L_RD;
                        end
                    end
                end
                ST_DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    ss_act_q <= 1'b0;
                    idx      <= 8'd0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ss_seq_ctrl.sv
// tb/tb_ss_seq_ctrl.sv - scoreboard bench for ss_seq_ctrl with mapper and memory models
module tb_ss_seq_ctrl;
    localparam int          SS_LEN    = 128;
    localparam int          IDX_ADDR  = 127;
    localparam int          RD_SETTLE = 4;
    localparam int          WE_HOLD   = 8;
    localparam logic [15:0] MEM_BASE  = 16'hFFC0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_save = 1'b0;
    logic start_load = 1'b0;
    logic busy, done, err;

    ss_seq_ctrl_if bus_if();

    logic [7:0] map_key = 8'hA5;
    logic [7:0] map_idx = 8'hDA;
    logic       mem_ack_r = 1'b0;
    logic [7:0] mem_rdat_r = 8'd0;
    logic [7:0] mem [0:65535];

    int total = 0, bad = 0;
    int dones = 0, strobes = 0, re_cyc = 0, we_cyc = 0, overlap = 0, act_gap = 0;
    int fixed_lat = 0, stall_next = 0;
    bit spur_ack = 1'b0;

    logic [23:0] exp_wr[$];
    logic [15:0] exp_stb[$];
    bit          exp_done[$];

    assign bus_if.ss_rdat  = (bus_if.ss_addr == 8'(IDX_ADDR)) ? map_idx : (bus_if.ss_addr ^ map_key);
    assign bus_if.mem_ack  = mem_ack_r;
    assign bus_if.mem_rdat = mem_rdat_r;

    always #5 clk = ~clk;

    ss_seq_ctrl #(
        .SS_LEN    (SS_LEN),
        .IDX_ADDR  (IDX_ADDR),
        .RD_SETTLE (RD_SETTLE),
        .WE_HOLD   (WE_HOLD),
        .MEM_BASE  (MEM_BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_save (start_save),
        .start_load (start_load),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bus        (bus_if)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
        end
    endtask

    function automatic logic [15:0] saddr(input int i);
        return 16'(MEM_BASE + 16'(i));
    endfunction

    // Expected memory image of a SAVE: every byte the mapper reports, in address order.
    task automatic push_save();
        logic [7:0] b;
        for (int i = 0; i < SS_LEN; i++) begin
            b = (i == IDX_ADDR) ? map_idx : (8'(i) ^ map_key);
            exp_wr.push_back({saddr(i), b});
        end
        exp_done.push_back(1'b0);
    endtask

    // Expected LOAD: one strobe per byte except the index byte, err on index mismatch.
    task automatic push_load();
        for (int i = 0; i < SS_LEN; i++)
            if (i != IDX_ADDR) exp_stb.push_back({8'(i), mem[saddr(i)]});
        exp_done.push_back(mem[saddr(IDX_ADDR)] != map_idx);
    endtask

    task automatic start(input logic s, input logic l);
        @(negedge clk);
        start_save = s;
        start_load = l;
        @(negedge clk);
        start_save = 1'b0;
        start_load = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int d0;
        int n;
        d0 = dones;
        n = 0;
        while (dones == d0 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_finished"}, 64'(dones != d0), 64'd1);
        repeat (4) @(negedge clk);
        chk({nm, "_queues_empty"}, 64'(exp_wr.size() + exp_stb.size() + exp_done.size()), 64'd0);
    endtask

    // Memory model: ack after a per-request latency, data valid in the ack cycle.
    initial begin : resp
        int wcnt;
        int lat;
        wcnt = 0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack_r = 1'b0;
                wcnt = 0;
            end else if (mem_ack_r) begin
                mem_ack_r = 1'b0;
                wcnt = 0;
            end else if (bus_if.mem_we || bus_if.mem_re) begin
                wcnt++;
                if (wcnt == 1) begin
                    if (stall_next > 0) begin
                        lat = stall_next;
                        stall_next = 0;
                    end else if (fixed_lat > 0) lat = fixed_lat;
                    else lat = int'($urandom_range(1, 4));
                end
                if (wcnt >= lat) begin
                    mem_ack_r = 1'b1;
                    if (bus_if.mem_re) mem_rdat_r = mem[bus_if.mem_addr];
                    else mem[bus_if.mem_addr] = bus_if.mem_wdat;
                end
            end else if (spur_ack) begin
                mem_ack_r = 1'b1;
                mem_rdat_r = 8'h5A;
                spur_ack = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard queues whenever the DUT presents a result.
    initial begin : mon
        logic       prev_we;
        logic [7:0] prev_addr, prev_wdat, st_addr, st_wdat;
        int         width;
        bit         stab;
        logic [15:0] e;
        logic [23:0] w;
        prev_we = 1'b0;
        prev_addr = 8'd0;
        prev_wdat = 8'd0;
        st_addr = 8'd0;
        st_wdat = 8'd0;
        width = 0;
        stab = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_we = 1'b0;
                width = 0;
                continue;
            end
            if (bus_if.mem_we && bus_if.mem_re) overlap++;
            if (bus_if.mem_re) re_cyc++;
            if (bus_if.mem_we) we_cyc++;
            if ((busy && !bus_if.ss_act) || (bus_if.ss_we && !bus_if.ss_act)) act_gap++;
            if (mem_ack_r && bus_if.mem_we) begin
                if (exp_wr.size() == 0) chk("mem_write_unexpected", {bus_if.mem_addr, bus_if.mem_wdat}, 64'd0);
                else begin
                    w = exp_wr.pop_front();
                    chk("mem_write", {bus_if.mem_addr, bus_if.mem_wdat}, w);
                end
            end
            if (bus_if.ss_we && !prev_we) begin
                st_addr = bus_if.ss_addr;
                st_wdat = bus_if.ss_wdat;
                width = 1;
                stab = (prev_addr == bus_if.ss_addr) && (prev_wdat == bus_if.ss_wdat);
            end else if (bus_if.ss_we) begin
                width++;
                if (bus_if.ss_addr != st_addr || bus_if.ss_wdat != st_wdat) stab = 1'b0;
            end else if (prev_we) begin
                if (bus_if.ss_addr != st_addr || bus_if.ss_wdat != st_wdat) stab = 1'b0;
                strobes++;
                if (exp_stb.size() == 0) chk("strobe_unexpected", {st_addr, st_wdat}, 64'd0);
                else begin
                    e = exp_stb.pop_front();
                    chk("strobe", {st_addr, st_wdat, 8'(width), 7'd0, stab}, {e, 8'(WE_HOLD), 8'd1});
                end
            end
            if (done === 1'b1) begin
                dones++;
                if (exp_done.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
                else chk("done_err_busy", {err, busy}, {exp_done.pop_front(), 1'b0});
            end
            prev_we = bus_if.ss_we;
            prev_addr = bus_if.ss_addr;
            prev_wdat = bus_if.ss_wdat;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int d0, r0, w0, s0, n;
        logic [15:0] a0;
        logic [7:0]  sa0;
        bit ok;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, err, bus_if.ss_act, bus_if.ss_we, bus_if.mem_we,
                              bus_if.mem_re, bus_if.ss_addr, bus_if.mem_addr}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        spur_ack = 1'b1;
        repeat (4) @(negedge clk);
        chk("spurious_ack_ignored", {busy, bus_if.mem_we, bus_if.mem_re, bus_if.ss_act}, 64'd0);

        // Directed SAVE: ss_rdat = addr ^ A5, ack 2 cycles after each request.
        fixed_lat = 2;
        map_key = 8'hA5;
        map_idx = 8'hDA;
        push_save();
        start(1'b1, 1'b0);
        wait_done("save_a5");
        chk("mem5", mem[saddr(5)], 8'hA0);
        chk("mem127", mem[saddr(127)], 8'hDA);
        fixed_lat = 0;

        // Directed LOAD with matching index byte.
        for (int i = 0; i < SS_LEN; i++) mem[saddr(i)] = 8'(i);
        map_idx = 8'h7F;
        s0 = strobes;
        push_load();
        start(1'b0, 1'b1);
        wait_done("load_match");
        chk("load_strobe_count", 64'(strobes - s0), 64'(SS_LEN - 1));
        chk("load_match_err", err, 1'b0);

        // LOAD with mismatching index byte, then SAVE clears err.
        mem[saddr(127)] = 8'h00;
        map_idx = 8'h06;
        push_load();
        start(1'b0, 1'b1);
        wait_done("load_mismatch");
        chk("err_sticky", err, 1'b1);
        push_save();
        start(1'b1, 1'b0);
        chk("err_cleared_busy", {err, busy}, 2'b01);
        wait_done("save_clear");

        // Simultaneous starts: SAVE wins; a start during busy is ignored.
        push_save();
        d0 = dones;
        r0 = re_cyc;
        w0 = we_cyc;
        start(1'b1, 1'b1);
        repeat (200) @(negedge clk);
        start(1'b0, 1'b1);
        wait_done("save_both");
        repeat (30) @(negedge clk);
        chk("one_done", 64'(dones - d0), 64'd1);
        chk("no_mem_re_in_save", 64'(re_cyc - r0), 64'd0);
        chk("mem_we_seen", 64'(we_cyc > w0), 64'd1);

        // Reset in the middle of the strobe at idx 40.
        for (int i = 0; i < SS_LEN; i++) mem[saddr(i)] = 8'($urandom);
        push_load();
        start(1'b0, 1'b1);
        n = 0;
        while (!(bus_if.ss_we && bus_if.ss_addr == 8'd40) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_idx40_strobe", 64'(n < 4000), 64'd1);
        repeat (3) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_drop", {bus_if.ss_we, bus_if.ss_act, busy, bus_if.mem_we, bus_if.mem_re}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        exp_stb.delete();
        exp_done.delete();
        exp_wr.delete();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {busy, done, bus_if.ss_act, bus_if.mem_we, bus_if.mem_re,
                                bus_if.ss_addr, bus_if.mem_addr}, 64'd0);
        map_key = 8'($urandom);
        push_save();
        start(1'b1, 1'b0);
        wait_done("save_after_reset");

        // mem_ack withheld for 50 cycles on the first SAVE write.
        stall_next = 50;
        map_key = 8'h3C;
        push_save();
        start(1'b1, 1'b0);
        n = 0;
        while (!bus_if.mem_we && n < 100) begin
            @(negedge clk);
            n++;
        end
        a0 = bus_if.mem_addr;
        sa0 = bus_if.ss_addr;
        ok = (n < 100) && (a0 == saddr(0)) && (sa0 == 8'd0);
        for (int k = 0; k < 47; k++) begin
            @(negedge clk);
            if (!bus_if.mem_we || bus_if.mem_re || bus_if.mem_addr != a0 || bus_if.ss_addr != sa0) ok = 1'b0;
        end
        chk("stall_hold", 64'(ok), 64'd1);
        wait_done("save_stall");

        // Randomized operations.
        for (int r = 0; r < 3; r++) begin
            map_key = 8'($urandom);
            map_idx = 8'($urandom);
            push_save();
            start(1'b1, 1'b0);
            wait_done("save_rand");
        end
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < SS_LEN; i++) mem[saddr(i)] = 8'($urandom);
            map_idx = 8'($urandom);
            if (r != 1) mem[saddr(IDX_ADDR)] = map_idx;
            push_load();
            start(1'b0, 1'b1);
            wait_done("load_rand");
        end

        chk("no_we_re_overlap", 64'(overlap), 64'd0);
        chk("ss_act_continuous", 64'(act_gap), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ss_seq_ctrl.md
Name: ss_seq_ctrl

Overview:
- Save-state sequencer; acts as the initiator on the mapper save-state bus (ss_act / ss_we / ss_addr / data) that every mapper answers.
- SAVE: walks mapper state addresses 0..SS_LEN-1, samples ss_rdat, writes each byte to snapshot memory.
- LOAD: reads snapshot memory and replays the bytes into the mapper as ss_we strobes.
- Sits between the menu/system controller and the mapper slot; one instance per slot.

Parameters:
- SS_LEN, 128, number of state bytes per snapshot (addresses 0..SS_LEN-1).
- IDX_ADDR, 127, read-only mapper index byte; compared on LOAD, never written.
- RD_SETTLE, 4, clk cycles between an ss_addr change and the ss_rdat sample.
- WE_HOLD, 8, clk cycles ss_we is held high with stable addr/data; must cover one full m2 period.
- MEM_BASE, 0, snapshot memory base address.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_save  in  1  one-cycle request; begin SAVE.
- start_load  in  1  one-cycle request; begin LOAD.
- busy  out  1  high from the accepted start until DONE exits.
- done  out  1  one-cycle pulse when an operation finishes.
- err  out  1  sticky index-mismatch flag; cleared by the next accepted start.
- ss_act  out  1  save-state bus active; mapper register writes are diverted.
- ss_we  out  1  save-state write strobe.
- ss_addr  out  8  save-state address.
- ss_wdat  out  8  data driven onto the CPU data lines during ss_we.
- ss_rdat  in  8  mapper save-state read data.
- mem_addr  out  16  snapshot memory address = MEM_BASE + ss index.
- mem_wdat  out  8  snapshot write data.
- mem_we  out  1  memory write request; held until mem_ack.
- mem_re  out  1  memory read request; held until mem_ack.
- mem_rdat  in  8  memory read data; valid in the mem_ack cycle.
- mem_ack  in  1  memory handshake completion.

Behaviour:
- Reset (async, rst_n low): state IDLE; every output 0; index counter 0; err 0. Reset mid-operation aborts immediately; ss_act and ss_we drop with no partial strobe completed.
- IDLE:
  - start_save -> S_SET. start_load -> L_RD. Both in the same cycle: SAVE wins.
  - An accepted start clears err and sets busy and ss_act on the next edge.
  - Starts while busy are ignored.
- SAVE path:
  - S_SET: drive ss_addr = idx; wait RD_SETTLE cycles.
  - S_WR: capture ss_rdat into mem_wdat; assert mem_we with mem_addr; hold until mem_ack (any number of wait cycles).
  - After ack: if idx == SS_LEN-1 -> DONE, else idx+1 -> S_SET.
  - Address 127 is saved like any other byte.
- LOAD path:
  - L_RD: assert mem_re until mem_ack; latch mem_rdat.
  - idx == IDX_ADDR -> L_CHK. Otherwise -> L_WE.
  - L_WE: ss_addr = idx, ss_wdat = latched byte. ss_addr and ss_wdat are stable 1 cycle before ss_we rises, ss_we is high for WE_HOLD cycles, and they stay stable 1 cycle after ss_we falls (L_GAP).
  - L_CHK: set ss_addr, wait RD_SETTLE cycles, compare ss_rdat to the latched byte; on mismatch set err. The operation continues either way.
  - Then last index -> DONE, else idx+1 -> L_RD.
- DONE: pulse done for 1 cycle; clear busy, ss_act and idx; -> IDLE.
- Widths: idx counter is 8-bit; no wrap beyond SS_LEN-1. mem_addr addition is 16-bit and wraps modulo 2^16.
- Memory handshake:
  - mem_we and mem_re are never high together.
  - Each is a level held from request until the ack cycle; it deasserts on the edge after ack.
  - An ack arriving with no request pending is ignored.
- ss_we is only ever asserted with ss_act high. ss_act stays high continuously for the whole operation.

Decomposition:
- Shared package: state enumeration, SS_LEN / IDX_ADDR defaults, MEM_BASE offsets per slot.
- One sub-module, ss_strobe_gen: the setup / WE_HOLD / hold timer producing ss_we, with req/fin handshake, reused by L_WE and by the RD_SETTLE wait.

Test Plan:
- SAVE with a mapper model returning ss_rdat = addr^8'hA5, mem_ack 2 cycles after each request -> 128 memory writes, mem[5] = 8'hA0, mem[127] = 8'hDA, single done pulse, err 0.
- LOAD with mem[i] = i, mem[127] matching the model index -> 127 ss_we strobes, each exactly WE_HOLD cycles with addr/data stable ±1 cycle; no strobe at addr 127; err 0.
- LOAD with mem[127] = 8'h00 while the model index is 8'h06 -> err = 1 after completion, done still pulses; next start_save clears err.
- start_save and start_load in the same cycle -> SAVE runs (mem_we seen, no mem_re); start_load pulse during busy -> ignored, exactly one done.
- rst_n low during a LOAD ss_we strobe at idx 40 -> ss_we, ss_act, busy drop asynchronously; after release, IDLE with idx 0 and no residual memory request.
- mem_ack held off 50 cycles at idx 0 during SAVE -> mem_we stays high and mem_addr stable for all 50 cycles; sequencer stalls without advancing ss_addr.
